exe_stage: RTL
==============

Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order MIPS pipeline (IF, ID, EXE, MEM, WB).
- Sits between id_stage and mem_stage.
- Registers the decoded instruction bundle from ID, selects ALU operands, computes the result through an ALU sub-module, and issues load/store requests to the synchronous data SRAM.
- Exports its destination and result to ID for hazard detection, forwarding and load-use stalls.

Parameters:
- none. All widths come from `define` constants in mycpu.h.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ms_allowin  in  1  MEM stage can accept an instruction this cycle.
- es_allowin  out  1  EXE can accept an instruction from ID this cycle.
- ds_to_es_valid  in  1  ID presents a valid instruction.
- ds_to_es_bus  in  136  {alu_op[135:124], load_op[123], src1_is_sa[122], src1_is_pc[121], src2_is_imm[120], src2_is_8[119], gr_we[118], mem_we[117], dest[116:112], imm[111:96], rs_value[95:64], rt_value[63:32], pc[31:0]}.
- es_to_ms_valid  out  1  EXE hands a valid instruction to MEM.
- es_to_ms_bus  out  71  {res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
- es_to_ds_hazard_bus  out  40  {es_valid[39], es_load_op[38], es_rf_we[37], es_rf_waddr[36:32], es_rf_wdata[31:0]}.
- data_sram_en  out  1  data SRAM access enable.
- data_sram_wen  out  4  byte write enables.
- data_sram_addr  out  32  byte address.
- data_sram_wdata  out  32  store data.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- On reset: es_valid is cleared to 0 and the bus register is cleared to 0.
  - es_to_ms_valid = 0, data_sram_en = 0, data_sram_wen = 0.
  - Hazard bus = 0.
  - es_allowin = 1.
- Handshake:
  - es_ready_go = 1; EXE has single-cycle latency.
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - es_to_ms_valid = es_valid && es_ready_go.
- Valid register: when es_allowin is high, es_valid <= ds_to_es_valid.
- Bus register: ds_to_es_bus is latched only when ds_to_es_valid && es_allowin. Otherwise it holds its value, so a stall keeps the instruction intact.
- Operand select:
  - src1 = src1_is_sa ? {27'b0, imm[10:6]} : src1_is_pc ? pc : rs_value.
  - src2 = src2_is_imm ? sign-extend(imm) : src2_is_8 ? 32'd8 : rt_value.
  - lui relies on the ALU shifting src2 left by 16, so sign extension is harmless there.
- ALU is combinational and uses the one-hot alu_op bit order from ID:
  - bit 0 add, bit 1 sub, bit 2 slt (signed), bit 3 sltu.
  - bits 4–7: and, nor, or, xor.
  - bits 8–10: sll, srl, sra; shift amount is src1[4:0] and src2 is the shifted value.
  - bit 11 lui = {src2[15:0], 16'b0}.
  - All add/sub arithmetic wraps modulo 2^32; overflow is ignored.
  - alu_op = 0 gives result 0.
- Memory request:
  - data_sram_en = es_valid && ms_allowin && (load_op || mem_we).
  - Requests issue only in the cycle the instruction advances to MEM; read data returns the next cycle, aligned with MEM.
  - data_sram_wen = {4{es_valid && ms_allowin && mem_we}}.
  - data_sram_addr = alu_result.
  - data_sram_wdata = rt_value.
  - Word access only; no alignment check.
- Output to MEM: res_from_mem = load_op.
- Hazard bus:
  - es_valid is raw.
  - es_load_op = load_op; es_rf_we = gr_we; es_rf_waddr = dest; es_rf_wdata = alu_result.
  - When es_valid = 0, consumers ignore the remaining fields.
- Boundary conditions:
  - MEM stalled with EXE full: es_allowin = 0, contents frozen, no SRAM enable.
  - Simultaneous drain and refill (es_valid = 1, ms_allowin = 1, ds_to_es_valid = 1): new instruction latched the same cycle; no bubble.
  - ds_to_es_valid = 0 while allowed in: es_valid becomes 0; the bus register is not updated.
  - Reset asserted mid-stall: instruction discarded next cycle; no pending SRAM write.

Decomposition:
- Shared definitions in mycpu.h: DS_TO_ES_BUS_WD = 136, ES_TO_MS_BUS_WD = 71, ES_TO_DS_HAZARD_BUS_WD = 40, and alu_op bit indices.
- One sub-module: alu, with inputs alu_op[11:0], alu_src1[31:0], alu_src2[31:0] and output alu_result[31:0]. It is purely combinational and reused by later ALU extensions.

Test Plan:
- addu: rs_value = 0x7FFFFFFF, rt_value = 1, ms_allowin = 1 -> next cycle es_to_ms_valid = 1, alu_result = 0x80000000, hazard wdata = 0x80000000, data_sram_en = 0.
- lw: rs_value = 0x1000, imm = 0xFFFC -> data_sram_en = 1, wen = 0, addr = 0x0FFC; hazard es_load_op = 1, es_rf_waddr = dest.
- sw with ms_allowin = 0 for 2 cycles then 1: rs_value = 0x2000, imm = 4, rt_value = 0xDEADBEEF -> es_allowin = 0, wen = 0 while stalled; exactly one cycle with wen = 0xF, addr = 0x2004, wdata = 0xDEADBEEF.
- jal with pc = 0xBFC00010 -> alu_result = 0xBFC00018, dest = 31.
- Mixed ops: sra with sa = 4, rt_value = 0x80000000 -> 0xF8000000. lui with imm = 0x1234 -> 0x12340000. slt with -1 vs 1 -> 1; sltu with the same operands -> 0.
- Back-to-back: ds_to_es_valid held high for 3 instructions with ms_allowin = 1 -> es_to_ms_valid high 3 consecutive cycles. Assert reset during the second -> es_to_ms_valid = 0 and data_sram_en = 0 the next cycle.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared widths and one-hot ALU operation bit positions for the EXE stage.
// The ID stage decodes alu_op in this same bit order.
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD        = 136;
    localparam int ES_TO_MS_BUS_WD        = 71;
    localparam int ES_TO_DS_HAZARD_BUS_WD = 40;
    localparam int ALU_OP_WD              = 12;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU with one-hot operation select.
// Shifts take the amount from src1[4:0] and shift src2.
module alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_WD-1:0] alu_op,
    input  logic [31:0]          alu_src1,
    input  logic [31:0]          alu_src2,
    output logic [31:0]          alu_result
);

    logic [31:0] w_add;
    logic [31:0] w_sub;
    logic [31:0] w_slt;
    logic [31:0] w_sltu;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;
    logic [31:0] w_lui;

    assign w_add  = alu_src1 + alu_src2;
    assign w_sub  = alu_src1 - alu_src2;
    assign w_slt  = {31'b0, ($signed(alu_src1) < $signed(alu_src2))};
    assign w_sltu = {31'b0, (alu_src1 < alu_src2)};
    assign w_sll  = alu_src2 << alu_src1[4:0];
    assign w_srl  = alu_src2 >> alu_src1[4:0];
    assign w_sra  = $signed(alu_src2) >>> alu_src1[4:0];
    assign w_lui  = {alu_src2[15:0], 16'b0};

    // One-hot select as an AND-OR mux; an all-zero op yields zero.
    assign alu_result = ({32{alu_op[ALU_ADD]}}  & w_add)
                      | ({32{alu_op[ALU_SUB]}}  & w_sub)
                      | ({32{alu_op[ALU_SLT]}}  & w_slt)
                      | ({32{alu_op[ALU_SLTU]}} & w_sltu)
                      | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
                      | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
                      | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
                      | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
                      | ({32{alu_op[ALU_SLL]}}  & w_sll)
                      | ({32{alu_op[ALU_SRL]}}  & w_srl)
                      | ({32{alu_op[ALU_SRA]}}  & w_sra)
                      | ({32{alu_op[ALU_LUI]}}  & w_lui);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the ID bundle, runs the ALU, issues data SRAM requests
// in the cycle the instruction advances to MEM, and exports a hazard bus to ID.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ms_allowin,
    output logic                              es_allowin,
    input  logic                              ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0]        ds_to_es_bus,
    output logic                              es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0]        es_to_ms_bus,
    output logic [ES_TO_DS_HAZARD_BUS_WD-1:0] es_to_ds_hazard_bus,
    output logic                              data_sram_en,
    output logic [3:0]                        data_sram_wen,
    output logic [31:0]                       data_sram_addr,
    output logic [31:0]                       data_sram_wdata
);

    logic                       r_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] r_ds_to_es_bus;

    logic [ALU_OP_WD-1:0] w_alu_op;
    logic                 w_load_op;
    logic                 w_src1_is_sa;
    logic                 w_src1_is_pc;
    logic                 w_src2_is_imm;
    logic                 w_src2_is_8;
    logic                 w_gr_we;
    logic                 w_mem_we;
    logic [4:0]           w_dest;
    logic [15:0]          w_imm;
    logic [31:0]          w_rs_value;
    logic [31:0]          w_rt_value;
    logic [31:0]          w_pc;

    logic [31:0] w_alu_src1;
    logic [31:0] w_alu_src2;
    logic [31:0] w_alu_result;
    logic        w_es_ready_go;
    logic        w_mem_issue;

    assign {w_alu_op, w_load_op, w_src1_is_sa, w_src1_is_pc, w_src2_is_imm,
            w_src2_is_8, w_gr_we, w_mem_we, w_dest, w_imm,
            w_rs_value, w_rt_value, w_pc} = r_ds_to_es_bus;

    assign w_es_ready_go  = 1'b1;
    assign es_allowin     = !r_es_valid || (w_es_ready_go && ms_allowin);
    assign es_to_ms_valid = r_es_valid && w_es_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_es_valid <= 1'b0;
        end else if (es_allowin) begin
            r_es_valid <= ds_to_es_valid;
        end
    end

    // Bus only moves on a real handoff so a stall or bubble keeps the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ds_to_es_bus <= '0;
        end else if (ds_to_es_valid && es_allowin) begin
            r_ds_to_es_bus <= ds_to_es_bus;
        end
    end

    assign w_alu_src1 = w_src1_is_sa ? {27'b0, w_imm[10:6]} :
                        w_src1_is_pc ? w_pc : w_rs_value;
    // lui shifts src2 by 16 in the ALU, so sign-extending its immediate is harmless.
    assign w_alu_src2 = w_src2_is_imm ? {{16{w_imm[15]}}, w_imm} :
                        w_src2_is_8   ? 32'd8 : w_rt_value;

    alu u_alu (
        .alu_op     (w_alu_op),
        .alu_src1   (w_alu_src1),
        .alu_src2   (w_alu_src2),
        .alu_result (w_alu_result)
    );

    assign w_mem_issue     = r_es_valid && ms_allowin;
    assign data_sram_en    = w_mem_issue && (w_load_op || w_mem_we);
    assign data_sram_wen   = {4{w_mem_issue && w_mem_we}};
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = w_rt_value;

    assign es_to_ms_bus        = {w_load_op, w_gr_we, w_dest, w_alu_result, w_pc};
    assign es_to_ds_hazard_bus = {r_es_valid, w_load_op, w_gr_we, w_dest, w_alu_result};

endmodule
